// File: rtl/gat_feat_bram_reader.sv
// gat_feat_bram_reader
//   Streams the new-feature BRAM (port B) out as one AXI-Stream frame per
//   start request, once gat_ready reports the results are final. Reads are
//   credit-limited so that the output FIFO never overflows. The FIFO hides the
//   BRAM read latency and absorbs downstream back-pressure.
//
// Ports
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   start            1-cycle frame request (ignored unless idle)
//   gat_ready        feature BRAM holds final results
//   feat_bram_addrb  byte address to the BRAM, bits [1:0] always 0
//   feat_bram_dout   BRAM read data, valid BRAM_RD_LATENCY cycles after addrb
//   m_axis_*         AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy             frame in progress
//   done             1-cycle pulse after the last beat is accepted
module gat_feat_bram_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done
);

  localparam int          CW  = NEW_FEATURE_ADDR_W + 1;
  localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          NW  = $clog2(FIFO_DEPTH + 1);
  localparam int          L   = BRAM_RD_LATENCY;
  localparam int unsigned FD  = FIFO_DEPTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(NEW_FEATURE_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                       state;
  logic [CW-1:0]                rd_idx;
  logic [CW-1:0]                tx_cnt;
  // Bit 0 marks the address currently on addrb; bit L marks the word whose
  // data is on feat_bram_dout this cycle and is written into the FIFO.
  logic [L:0]                   vld_sr;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [NW-1:0]                fifo_count;

  logic        issue;
  logic        push;
  logic        pop;
  logic        last_issue;
  logic        last_beat;
  int unsigned inflight;
  int unsigned occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = fifo_mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && (tx_cnt == LAST_IDX);

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i <= L; i++) begin
      inflight += 32'(vld_sr[i]);
    end
    pop  = m_axis_tvalid && m_axis_tready;
    push = vld_sr[L];
    // A word popped this cycle frees its slot immediately, which keeps one
    // word per cycle flowing with tready held high.
    occupancy  = 32'(fifo_count) + inflight - 32'(pop);
    // The first read goes out on the same edge that leaves WAIT_RDY.
    issue      = ((state == READ) || ((state == WAIT_RDY) && gat_ready)) && (occupancy < FD);
    last_issue = issue && (rd_idx == LAST_IDX);
    last_beat  = pop && (tx_cnt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_idx          <= '0;
      tx_cnt          <= '0;
      feat_bram_addrb <= '0;
      vld_sr          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      for (int unsigned i = 0; i < FD; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      vld_sr <= {vld_sr[L-1:0], issue};

      if (issue) begin
        feat_bram_addrb <= (NEW_FEATURE_ADDR_W + 2)'({rd_idx, 2'b00});
        rd_idx          <= rd_idx + 1'b1;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= feat_bram_dout;
        wr_ptr           <= ptr_inc(wr_ptr);
      end

      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        tx_cnt <= tx_cnt + 1'b1;
      end

      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end

      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= WAIT_RDY;
            busy   <= 1'b1;
            rd_idx <= '0;
            tx_cnt <= '0;
          end
        end
        WAIT_RDY: begin
          if (gat_ready) begin
            state <= last_issue ? DRAIN : READ;
          end
        end
        READ: begin
          if (last_issue) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_beat) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gat_feat_bram_reader.sv
// tb_gat_feat_bram_reader
//   Bench for gat_feat_bram_reader with a 16-word frame. A BRAM model returns
//   mem[addrb/4] after BRAM_RD_LATENCY cycles; the expected stream is simply
//   mem[0..15] in order with tlast on the final word and one done per frame.
module tb_gat_feat_bram_reader;

  localparam int L     = 2;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          gat_ready;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;

  gat_feat_bram_reader #(
    .NEW_FEATURE_WIDTH (32),
    .NUM_SUBGRAPHS     (1),
    .NUM_FEATURE_OUT   (DEPTH),
    .BRAM_RD_LATENCY   (L),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .gat_ready       (gat_ready),
    .feat_bram_addrb (feat_bram_addrb),
    .feat_bram_dout  (feat_bram_dout),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // BRAM model
  logic [31:0] mem     [DEPTH];
  logic [31:0] rd_pipe [L];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[feat_bram_addrb[AW+1:2]];
    for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign feat_bram_dout = rd_pipe[L-1];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // tready driver: 0 = always ready, 1 = ready 30% of cycles, 2 = never ready
  int rdy_mode = 0;
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 99) < 30);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Stream monitor / scoreboard
  int          mon_on     = 0;
  int          beat_idx   = 0;
  int          done_cnt   = 0;
  int          exp_done   = 0;
  int          stall_prev = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [31:0] last_addr;
  logic [31:0] next_addr;
  int          addr_moves = 0;

  always @(negedge clk) begin
    if (mon_on != 0) begin
      if (stall_prev != 0) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (exp_done != 0) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        exp_done = 0;
      end else begin
        check("done_quiet", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (beat_idx < DEPTH) begin
          check("beat_data", m_axis_tdata, mem[beat_idx]);
          check("beat_last", 32'(m_axis_tlast), 32'(beat_idx == DEPTH - 1));
        end else begin
          check("extra_beat", 32'(beat_idx), 32'(DEPTH - 1));
        end
        if (beat_idx == DEPTH - 1) exp_done = 1;
        beat_idx++;
      end
      if (32'(feat_bram_addrb) != last_addr) begin
        check("addr_seq", 32'(feat_bram_addrb), next_addr);
        last_addr  = 32'(feat_bram_addrb);
        next_addr  = next_addr + 4;
        addr_moves++;
      end
      stall_prev = (m_axis_tvalid && !m_axis_tready) ? 1 : 0;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else begin
      stall_prev = 0;
      exp_done   = 0;
    end
  end

  // mode 2 holds tready low for 20 cycles, then releases it with no gaps allowed
  task automatic run_frame(input int gdelay, input int mode, input int restart_at, input int reset_at);
    int          n;
    logic [31:0] start_addr;
    foreach (mem[i]) mem[i] = $urandom;
    beat_idx   = 0;
    done_cnt   = 0;
    addr_moves = 0;
    start_addr = 32'(feat_bram_addrb);
    last_addr  = start_addr;
    next_addr  = (start_addr == 0) ? 32'd4 : 32'd0;
    rdy_mode   = mode;
    @(posedge clk);
    #1;
    start     = 1'b1;
    gat_ready = (gdelay == 0);
    mon_on    = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (gdelay == 0 && mode == 0 && restart_at < 0 && reset_at < 0) begin
      for (int k = 1; k <= L + 3; k++) begin
        @(negedge clk);
        check("first_valid", 32'(m_axis_tvalid), 32'(k == L + 3));
      end
    end
    if (gdelay > 0) begin
      repeat (gdelay) begin
        @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_addr", 32'(feat_bram_addrb), start_addr);
      end
      @(posedge clk);
      #1;
      gat_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    gat_ready = 1'b0;

    if (mode == 2) begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("stall_addr", 32'(feat_bram_addrb), 32'd12);
      check("stall_full", 32'(m_axis_tvalid), 32'd1);
      check("stall_beats", 32'(beat_idx), 32'd0);
      rdy_mode = 0;
      @(posedge clk);
      #2;
      for (int k = 0; k < DEPTH; k++) begin
        @(negedge clk);
        check("no_gap", 32'(m_axis_tvalid), 32'd1);
      end
    end

    if (restart_at >= 0) begin
      n = 0;
      while (beat_idx < restart_at && n < 1000) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end

    if (reset_at >= 0) begin
      n = 0;
      while (beat_idx < reset_at && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("reset_reached", 32'(beat_idx >= reset_at), 32'd1);
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      mon_on = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("abort_valid", 32'(m_axis_tvalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
      end
      return;
    end

    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    repeat (4) @(negedge clk);
    check("done_once", 32'(done_cnt), 32'd1);
    check("beat_count", 32'(beat_idx), 32'(DEPTH));
    check("addr_final", 32'(feat_bram_addrb), 32'((DEPTH - 1) * 4));
    check("addr_moves", 32'(addr_moves), 32'(DEPTH - ((start_addr == 0) ? 1 : 0)));
    check("idle_busy", 32'(busy), 32'd0);
    mon_on = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    gat_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(m_axis_tvalid), 32'd0);
    check("rst_last", 32'(m_axis_tlast), 32'd0);
    check("rst_data", m_axis_tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(feat_bram_addrb), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(0, 0, -1, -1);   // gat_ready already high, tready high
    run_frame(50, 0, -1, -1);  // long wait for gat_ready
    run_frame(0, 1, -1, -1);   // random back-pressure
    run_frame($urandom_range(1, 8), 1, -1, -1);
    run_frame(0, 2, -1, -1);   // full stall then release
    run_frame(0, 0, -1, 8);    // reset mid-frame
    run_frame(0, 0, -1, -1);   // fresh frame after abort
    run_frame(0, 0, 5, -1);    // start pulsed again mid-frame

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
